// File: rtl/led_pio_pkg.sv
// Package: led_pio_pkg
// Shared register map and STATUS field layout for the LED blink PIO.
//   ADDR_*            word addresses of the eight slave registers
//   STATUS_PHASE_BIT  STATUS bit carrying the current blink phase
//   STATUS_OUT_LSB    STATUS bit where the out_port image starts
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_OUT_LSB   = 8;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Module: led_pio_blink_timer
// Blink timebase: a prescaler producing a tick every (prescale+1) clk and a
// half-period stage that flips phase every (period+1) ticks.
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   restart   in   a PERIOD/PRESCALE write lands this cycle
//   prescale  in   prescaler reload value
//   period    in   half-period reload value
//   phase     out  blink phase, 1 after reset/restart
//   tick      out  prescaler terminal count this cycle
module led_pio_blink_timer
  import led_pio_pkg::*;
#(
  parameter int PRESCALE_W = 24,
  parameter int PERIOD_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PERIOD_W-1:0]   period,
  output logic                  phase,
  output logic                  tick
);

  // Both counters hold elapsed counts and terminate when they reach the
  // programmed value. Clearing them on restart therefore yields a full
  // (prescale+1)*(period+1) clk interval before the first phase flip, and a
  // counter can never run past its terminal value because the limit only
  // changes together with a restart.
  logic [PRESCALE_W-1:0] pcnt;
  logic [PERIOD_W-1:0]   hcnt;

  // Restart has priority: no tick is reported in the restart cycle.
  assign tick = (pcnt == prescale) && !restart;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt  <= '0;
      hcnt  <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      pcnt  <= '0;
      hcnt  <= '0;
      phase <= 1'b1;
    end else begin
      if (tick) begin
        pcnt <= '0;
        if (hcnt == period) begin
          hcnt  <= '0;
          phase <= ~phase;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pio_blink.sv
// Module: led_pio_blink
// Avalon-MM output PIO for LED banks with atomic set/clear/toggle and
// per-bit hardware blink. Zero read latency, no wait states.
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   address     in   word register index
//   chipselect  in   slave select
//   write_n     in   active-low write strobe, qualified by chipselect
//   writedata   in   write data, upper bits beyond register width ignored
//   readdata    out  combinational, zero-extended read data
//   out_port    out  LED drive
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 24,
  parameter int PERIOD_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                  wr;
  logic                  restart;
  logic                  phase;
  logic                  unused_tick;
  logic                  unused_wd;
  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      mode;
  logic [WIDTH-1:0]      wd;
  logic [PERIOD_W-1:0]   period;
  logic [PRESCALE_W-1:0] prescale;
  logic [63:0]           status_wide;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign restart = wr && (address == ADDR_PERIOD || address == ADDR_PRESCALE);

  // Writedata bits above each register's width are deliberately dropped.
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= '0;
      mode     <= '0;
      period   <= '0;
      prescale <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data     <= wd;
        ADDR_MODE:     mode     <= wd;
        ADDR_PERIOD:   period   <= writedata[PERIOD_W-1:0];
        ADDR_PRESCALE: prescale <= writedata[PRESCALE_W-1:0];
        ADDR_OUTSET:   data     <= data | wd;
        ADDR_OUTCLEAR: data     <= data & ~wd;
        ADDR_TOGGLE:   data     <= data ^ wd;
        default:       ;
      endcase
    end
  end

  led_pio_blink_timer #(
    .PRESCALE_W (PRESCALE_W),
    .PERIOD_W   (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .prescale (prescale),
    .period   (period),
    .phase    (phase),
    .tick     (unused_tick)
  );

  // Blink bits are masked out while phase is low; DATA is zero in reset.
  assign out_port = data & (~mode | {WIDTH{phase}});

  // STATUS is assembled in a wide vector so a WIDTH near 32 simply truncates
  // at bit 31 instead of indexing past the bus.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status_wide                                  = '0;
    status_wide[STATUS_OUT_LSB +: WIDTH]         = out_port;
    status_wide[STATUS_PHASE_BIT]                = phase;
    readdata                                     = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]      = data;
      ADDR_MODE:     readdata[WIDTH-1:0]      = mode;
      ADDR_PERIOD:   readdata[PERIOD_W-1:0]   = period;
      ADDR_PRESCALE: readdata[PRESCALE_W-1:0] = prescale;
      ADDR_STATUS:   readdata                 = status_wide[31:0];
      default:       readdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Testbench: tb_led_pio_blink
// Directed and randomized checks of led_pio_blink against a cycle-level
// reference model that tracks phase as "clocks elapsed since the last
// restart" against the product (PRESCALE+1)*(PERIOD+1).
module tb_led_pio_blink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [31:0] readdata3;
  logic [2:0]  out_port3;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]  m_data, m_mode;
  logic [31:0] m_period, m_prescale;
  logic        m_phase;
  longint      m_elapsed;
  bit          m_restart;

  led_pio_blink #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  led_pio_blink #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata3),
    .out_port(out_port3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_out();
    return m_data & (~m_mode | {8{m_phase}});
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_mode};
      3'd2: return m_period;
      3'd3: return m_prescale;
      3'd7: return {16'd0, model_out(), 7'd0, m_phase};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = '0; m_mode = '0; m_period = '0; m_prescale = '0;
      m_phase = 1'b1; m_elapsed = 0;
    end else begin
      m_restart = 1'b0;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_mode = writedata[7:0];
          3'd2: begin m_period = writedata & 32'h0000_FFFF; m_restart = 1'b1; end
          3'd3: begin m_prescale = writedata & 32'h00FF_FFFF; m_restart = 1'b1; end
          3'd4: m_data = m_data | writedata[7:0];
          3'd5: m_data = m_data & ~writedata[7:0];
          3'd6: m_data = m_data ^ writedata[7:0];
          default: ;
        endcase
      end
      if (m_restart) begin
        m_phase = 1'b1;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= (longint'(m_prescale) + 1) * (longint'(m_period) + 1)) begin
          m_phase = ~m_phase;
          m_elapsed = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("out_port", {24'd0, out_port}, {24'd0, model_out()});
  end

  // Drives a write starting now; returns just after the capturing edge.
  task automatic drive_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_write(a, d);
  endtask

  task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd;
    logic        exp_ph;

    // Power-on reset
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Width truncation on the 3-bit instance
    do_write(3'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    address = 3'd0; #1;
    check("w3_data", readdata3, 32'h7);
    check("w3_out", {29'd0, out_port3}, 32'h7);
    address = 3'd7; #1;
    check("w3_status", {29'd0, readdata3[10:8]}, 32'h7);

    // Atomic set/clear/toggle
    do_write(3'd0, 32'hA5);
    do_write(3'd4, 32'h0F);
    do_read("outset", 3'd0, 32'hAF);
    do_write(3'd5, 32'h81);
    do_read("outclear", 3'd0, 32'h2E);
    do_write(3'd6, 32'hFF);
    do_read("toggle", 3'd0, 32'hD1);
    do_read("rd_outset", 3'd4, 32'h0);
    do_read("rd_outclear", 3'd5, 32'h0);
    do_read("rd_toggle", 3'd6, 32'h0);

    // Blink timing: 8 clk on, 8 clk off for the blinking nibble
    do_write(3'd0, 32'hFF);
    do_write(3'd1, 32'h0F);
    do_write(3'd3, 32'd3);
    do_write(3'd2, 32'd1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check("blink", {24'd0, out_port}, ((k / 8) % 2 == 0) ? 32'hFF : 32'hF0);
    end

    // Reset asserted mid-blink
    @(negedge clk);
    #3 reset = 1'b1;
    #1 check("rst_out", {24'd0, out_port}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 check($sformatf("rst_rd%0d", a), readdata, (a == 7) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Fast edge: phase flips every clk, then a PERIOD restart mid-phase-0
    do_write(3'd3, 32'd0);
    do_write(3'd2, 32'd0);
    address = 3'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("fast_phase", {31'd0, readdata[0]}, {31'd0, (k % 2 == 0)});
    end
    drive_write(3'd2, 32'd2);
    address = 3'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_ph = (k < 3);
      check("restart_phase", {31'd0, readdata[0]}, {31'd0, exp_ph});
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1: begin
          address = ra; chipselect = 1'b1; write_n = 1'b1;
          #1 check("rand_rd", readdata, model_read(ra));
        end
        2: begin
          rd = $urandom;
          if (ra == 3'd2 || ra == 3'd3)
            rd = ($urandom & 32'hFF00_0000) | $urandom_range(0, 3);
          address = ra; writedata = rd; chipselect = 1'b1; write_n = 1'b0;
        end
        default: begin
          address = ra; writedata = $urandom; chipselect = 1'b0;
          write_n = 1'($urandom_range(0, 1));
        end
      endcase
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
